// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared types and sensor limits for the HC-SR04 distance filter.
package hcsr04_pkg;
    typedef logic [11:0] dist_mm_t;
    typedef enum logic {FILL, RUN} flt_state_t;
    localparam dist_mm_t SENSOR_MIN_MM = 12'd20;
    localparam dist_mm_t SENSOR_MAX_MM = 12'd4000;
endpackage

// File: rtl/hcsr04_dist_filter_if.sv
// hcsr04_dist_filter_if: sample input and filtered-output bundle of the distance filter.
interface hcsr04_dist_filter_if;
    import hcsr04_pkg::*;
    logic clear;
    logic in_val;
    dist_mm_t in_dist;
    logic avg_val;
    dist_mm_t avg_dist;
    logic ready;
    logic near;
    logic [7:0] reject_cnt;
    modport master(output clear, in_val, in_dist, input avg_val, avg_dist, ready, near, reject_cnt);
    modport slave(input clear, in_val, in_dist, output avg_val, avg_dist, ready, near, reject_cnt);
endinterface

// File: rtl/hcsr04_ring_buf.sv
// hcsr04_ring_buf: sample window storage; rdata is the entry the next write will overwrite.
module hcsr04_ring_buf import hcsr04_pkg::*; #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     we,
    input  dist_mm_t wdata,
    output dist_mm_t rdata
);
    logic [DEPTH_LOG2-1:0] wr_ptr;
    dist_mm_t mem [2**DEPTH_LOG2];

    assign rdata = mem[wr_ptr];

    always_ff @(posedge clk)
        if (we) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst)
        if (!rst) wr_ptr <= '0;
        else if (clear) wr_ptr <= '0;
        else if (we) wr_ptr <= wr_ptr + 1'b1;
endmodule

// File: rtl/hcsr04_dist_filter.sv
// hcsr04_dist_filter: range-gated moving average of HC-SR04 distances with a
// hysteretic proximity flag and a saturating reject counter.
module hcsr04_dist_filter import hcsr04_pkg::*; #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter dist_mm_t MIN_MM = SENSOR_MIN_MM,
    parameter dist_mm_t MAX_MM = SENSOR_MAX_MM,
    parameter dist_mm_t NEAR_ON_MM = 12'd300,
    parameter dist_mm_t NEAR_OFF_MM = 12'd350
) (
    input logic clk,
    input logic rst,
    hcsr04_dist_filter_if.slave bus
);
    localparam int unsigned SW = 12 + DEPTH_LOG2;
    localparam logic [0:0] S_FILL = FILL;
    localparam logic [0:0] S_RUN = RUN;

    logic [0:0] state;
    logic [DEPTH_LOG2-1:0] fill_cnt;
    logic s1_val, s1_emit, s2_emit;
    dist_mm_t s1_new, s1_old, rd, avg_dist, avg_new;
    logic [SW-1:0] sum;
    logic avg_val, near;
    logic [7:0] reject_cnt;
    logic in_range, accept, reject;

    assign in_range = bus.in_dist >= MIN_MM && bus.in_dist <= MAX_MM;
    assign accept = bus.in_val && !bus.clear && in_range;
    assign reject = bus.in_val && !bus.clear && !in_range;
    assign avg_new = sum[SW-1:DEPTH_LOG2];

    hcsr04_ring_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
        .clk(clk),
        .rst(rst),
        .clear(bus.clear),
        .we(accept),
        .wdata(bus.in_dist),
        .rdata(rd)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            {state, fill_cnt, s1_val, s1_emit, s1_new, s1_old, s2_emit, sum} <= '0;
            {avg_val, avg_dist, near, reject_cnt} <= '0;
        end else if (bus.clear) begin
            {state, fill_cnt, s1_val, s1_emit, s1_new, s1_old, s2_emit, sum} <= '0;
            {avg_val, avg_dist, near, reject_cnt} <= '0;
        end else begin
            s1_val <= accept;
            s1_emit <= accept && (state == S_RUN || fill_cnt == '1);
            if (accept) begin
                s1_new <= bus.in_dist;
                // buffer contents are stale until the first full pass
                s1_old <= state == S_RUN ? rd : '0;
                if (state == S_FILL) fill_cnt <= fill_cnt + 1'b1;
                if (state == S_FILL && fill_cnt == '1) state <= S_RUN;
            end
            if (s1_val) sum <= sum + SW'(s1_new) - SW'(s1_old);
            s2_emit <= s1_emit;
            avg_val <= s2_emit;
            if (s2_emit) begin
                avg_dist <= avg_new;
                near <= near ? avg_new < NEAR_OFF_MM : avg_new <= NEAR_ON_MM;
            end
            if (reject && reject_cnt != 8'hff) reject_cnt <= reject_cnt + 1'b1;
        end

    assign bus.avg_val = avg_val;
    assign bus.avg_dist = avg_dist;
    assign bus.ready = state == S_RUN;
    assign bus.near = near;
    assign bus.reject_cnt = reject_cnt;
endmodule

// File: tb/tb_hcsr04_dist_filter.sv
// tb_hcsr04_dist_filter: directed and random stimulus checked every cycle
// against a window-of-samples reference model.
module tb_hcsr04_dist_filter;
    import hcsr04_pkg::*;
    localparam int D = 3;
    localparam int N = 1 << D;

    typedef struct {int due; int avg;} pend_t;

    logic clk = 0;
    logic rst = 0;
    int checks = 0, errors = 0, strobes = 0, cyc = 0, s0 = 0;
    int window[$];
    pend_t pend[$];
    int e_avg, e_rej;
    bit e_val, e_near;

    hcsr04_dist_filter_if bus();
    hcsr04_dist_filter #(.DEPTH_LOG2(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        window.delete();
        pend.delete();
        e_avg = 0;
        e_rej = 0;
        e_val = 0;
        e_near = 0;
    endtask

    // one clock edge of the reference: emit any due average, then take the new sample
    task automatic model(input bit v, input int d, input bit c);
        cyc++;
        e_val = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_val = 1;
            e_avg = pend[0].avg;
            void'(pend.pop_front());
            if (e_near && e_avg >= 350) e_near = 0;
            else if (!e_near && e_avg <= 300) e_near = 1;
        end
        if (v) begin
            if (d >= 20 && d <= 4000) begin
                window.push_back(d);
                if (window.size() > N) void'(window.pop_front());
                if (window.size() == N) begin
                    int s = 0;
                    foreach (window[i]) s += window[i];
                    pend.push_back('{cyc + 2, s / N});
                end
            end else if (e_rej < 255) e_rej++;
        end
    endtask

    task automatic compare();
        check("avg_val", bus.avg_val, e_val);
        check("avg_dist", bus.avg_dist, e_avg);
        check("ready", bus.ready, window.size() == N);
        check("near", bus.near, e_near);
        check("reject_cnt", bus.reject_cnt, e_rej);
        if (bus.avg_val) strobes++;
    endtask

    task automatic step(input bit v, input int d, input bit c);
        bus.in_val = v;
        bus.in_dist = dist_mm_t'(d);
        bus.clear = c;
        @(posedge clk);
        model(v, d, c);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic feed(input int n, input int d);
        repeat (n) step(1, d, 0);
    endtask

    task automatic do_reset();
        #2;
        rst = 0;
        bus.in_val = 0;
        bus.clear = 0;
        #1;
        check("rst_avg_val", bus.avg_val, 0);
        check("rst_avg_dist", bus.avg_dist, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_near", bus.near, 0);
        check("rst_reject_cnt", bus.reject_cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        bus.in_val = 0;
        bus.in_dist = '0;
        bus.clear = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;

        // mid-stream reset, then a partial fill must stay silent
        feed(N + 3, 1000);
        step(1, 3000, 0);
        step(1, 5, 0);
        do_reset();
        s0 = strobes;
        feed(N - 1, 1500);
        idle(3);
        check("t1_no_strobe", strobes - s0, 0);

        do_reset();
        s0 = strobes;
        feed(N, 1000);
        idle(2);
        check("t2_strobes", strobes - s0, 1);
        check("t2_avg", bus.avg_dist, 1000);
        check("t2_ready", bus.ready, 1);

        step(1, 1800, 0);
        idle(2);
        check("t3_avg_1800", bus.avg_dist, 1100);
        step(1, 1001, 0);
        idle(2);
        check("t3_avg_trunc", bus.avg_dist, 1100);

        step(1, 19, 0);
        step(1, 4001, 0);
        step(1, 20, 0);
        step(1, 4000, 0);
        check("t4_rejects", bus.reject_cnt, 2);
        idle(2);

        feed(N, 290);
        idle(2);
        check("t5_avg290", bus.avg_dist, 290);
        check("t5_near_on", bus.near, 1);
        feed(N, 320);
        idle(2);
        check("t5_near_hold", bus.near, 1);
        feed(N - 1, 350);
        idle(2);
        check("t5_near_346", bus.near, 1);
        step(1, 350, 0);
        idle(2);
        check("t5_avg350", bus.avg_dist, 350);
        check("t5_near_off", bus.near, 0);

        step(1, 19, 0);
        step(1, 500, 1);
        check("t6_ready", bus.ready, 0);
        check("t6_rejects", bus.reject_cnt, 0);
        s0 = strobes;
        step(1, 500, 0);
        step(0, 0, 1);
        idle(3);
        check("t6_flush", strobes - s0, 0);
        feed(N - 1, 600);
        check("t6_not_ready", bus.ready, 0);
        step(1, 600, 0);
        check("t6_ready_again", bus.ready, 1);
        idle(2);
        check("t6_avg", bus.avg_dist, 600);

        feed(260, 4095);
        check("sat_rejects", bus.reject_cnt, 255);

        for (int i = 0; i < 800; i++) begin
            int r = $urandom_range(0, 99);
            int d = r < 10 ? $urandom_range(0, 4095) :
                    r < 15 ? $urandom_range(15, 25) : $urandom_range(200, 450);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 59) == 0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
